// File: rtl/o_serdes_tx_pkg.sv
// ----------------------------------------------------------------------------
// o_serdes_tx_pkg
//   Shared constants for the transmit gearbox: FSM state encoding, the
//   lead/trail counter width and a helper that sizes the beat counter.
//   No ports.
// ----------------------------------------------------------------------------
package o_serdes_tx_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    // Lead/trail counter width; holds OE_LEAD-1 / OE_TRAIL-1 (0..14)
    localparam int CNT_W = 4;

    // Beat counter width for a word of w bits (w/2 beats)
    function automatic int beat_w(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/o_serdes_tx_if.sv
// ----------------------------------------------------------------------------
// o_serdes_tx_if
//   Word handshake between fabric logic and the transmit gearbox.
//   DATA_IN    word to transmit            (master -> slave)
//   DATA_VALID DATA_IN valid               (master -> slave)
//   DATA_READY slave accepts on this edge  (slave -> master)
// ----------------------------------------------------------------------------
interface o_serdes_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  DATA_VALID;
    logic                  DATA_READY;

    modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
    modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/io_hold_reg.sv
// ----------------------------------------------------------------------------
// io_hold_reg
//   One-entry valid/ready holding register, shared with the receive gearbox.
//   clk, rst_n           clock, async active-low reset
//   en                   clock enable; low freezes the entry and drops in_ready
//   in_data/in_valid     write side; in_ready = en & entry empty
//   pop                  consumer takes out_data on this edge
//   out_data/out_valid   held word
// ----------------------------------------------------------------------------
module io_hold_reg
    import o_serdes_tx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         pop,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    assign in_ready = en & ~out_valid;

    // Write and pop never coincide: a write needs the entry empty, a pop needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/o_serdes_tx.sv
// ----------------------------------------------------------------------------
// o_serdes_tx
//   Transmit gearbox: DATA_WIDTH-bit words in, 2 bits per cycle out to an
//   O_DDR cell, plus the output enable for the tristate/differential buffer.
//   C      clock
//   R      async active-low reset
//   EN     clock enable; low freezes everything and drops DATA_READY
//   s_if   word handshake (DATA_IN / DATA_VALID / DATA_READY)
//   Q      to O_DDR D; Q[0] is the earlier (rising-half) bit
//   OE     output enable, with OE_LEAD / OE_TRAIL idle cycles around a burst
//   BUSY   FSM not idle or a word is waiting in the hold register
//
//   state | meaning
//   IDLE  | OE low, Q=IDLE_PAT, waiting for a held word
//   LEAD  | OE high, Q=IDLE_PAT, counting OE_LEAD cycles before the first beat
//   SHIFT | OE high, one data beat on Q per cycle
//   TRAIL | OE high, Q=IDLE_PAT, counting OE_TRAIL cycles after the last beat
// ----------------------------------------------------------------------------
module o_serdes_tx
    import o_serdes_tx_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter bit         LSB_FIRST  = 1'b1,
    parameter int         OE_LEAD    = 0,
    parameter int         OE_TRAIL   = 1,
    parameter logic [1:0] IDLE_PAT   = 2'b00
) (
    input  logic        C,
    input  logic        R,
    input  logic        EN,
    o_serdes_tx_if.slave s_if,
    output logic [1:0]  Q,
    output logic        OE,
    output logic        BUSY
);

    localparam int NB = DATA_WIDTH / 2;
    localparam int BW = beat_w(DATA_WIDTH);

    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 32) begin : g_bad_width
        $error("o_serdes_tx: DATA_WIDTH must be even and within 4..32");
    end
    if (OE_LEAD < 0 || OE_LEAD > 15 || OE_TRAIL < 0 || OE_TRAIL > 15) begin : g_bad_oe
        $error("o_serdes_tx: OE_LEAD and OE_TRAIL must be within 0..15");
    end

    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_vld;
    logic                  load;
    logic [DATA_WIDTH-1:0] ordered;
    logic [DATA_WIDTH-1:0] sr;
    logic [1:0]            state;
    logic [BW-1:0]         beat_cnt;
    logic [CNT_W-1:0]      oe_cnt;

    io_hold_reg #(.W(DATA_WIDTH)) u_hold (
        .clk       (C),
        .rst_n     (R),
        .en        (EN),
        .in_data   (s_if.DATA_IN),
        .in_valid  (s_if.DATA_VALID),
        .in_ready  (s_if.DATA_READY),
        .pop       (load),
        .out_data  (hold_data),
        .out_valid (hold_vld)
    );

    // Reorder the held word so beat i always sits in bits [2i+1:2i]; the
    // shift register then only ever shifts right by two.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < NB; i++) begin
            if (LSB_FIRST)
                ordered[2*i +: 2] = hold_data[2*i +: 2];
            else
                ordered[2*i +: 2] = {hold_data[DATA_WIDTH-2-2*i], hold_data[DATA_WIDTH-1-2*i]};
        end
    end

    // Edges that move the held word into the shift register. A word waiting
    // in TRAIL goes straight out without a LEAD phase.
    always_comb begin
        load = 1'b0;
        if (EN && hold_vld) begin
            case (state)
                ST_IDLE:  load = (OE_LEAD == 0);
                ST_LEAD:  load = (oe_cnt == '0);
                ST_SHIFT: load = (beat_cnt == '0);
                ST_TRAIL: load = 1'b1;
                default:  load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state    <= ST_IDLE;
            Q        <= IDLE_PAT;
            OE       <= 1'b0;
            sr       <= '0;
            beat_cnt <= '0;
            oe_cnt   <= '0;
        end else if (EN) begin
            if (load) begin
                state    <= ST_SHIFT;
                Q        <= ordered[1:0];
                sr       <= ordered >> 2;
                OE       <= 1'b1;
                beat_cnt <= BW'(NB - 1);
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Only reached with OE_LEAD > 0; otherwise load took it.
                        if (hold_vld) begin
                            state  <= ST_LEAD;
                            OE     <= 1'b1;
                            oe_cnt <= CNT_W'(OE_LEAD - 1);
                        end
                    end
                    ST_LEAD: begin
                        if (oe_cnt != '0)
                            oe_cnt <= oe_cnt - CNT_W'(1);
                    end
                    ST_SHIFT: begin
                        if (beat_cnt != '0) begin
                            Q        <= sr[1:0];
                            sr       <= sr >> 2;
                            beat_cnt <= beat_cnt - BW'(1);
                        end else begin
                            Q <= IDLE_PAT;
                            if (OE_TRAIL > 0) begin
                                state  <= ST_TRAIL;
                                oe_cnt <= CNT_W'(OE_TRAIL - 1);
                            end else begin
                                state <= ST_IDLE;
                                OE    <= 1'b0;
                            end
                        end
                    end
                    ST_TRAIL: begin
                        if (oe_cnt == '0) begin
                            state <= ST_IDLE;
                            OE    <= 1'b0;
                        end else begin
                            oe_cnt <= oe_cnt - CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign BUSY = (state != ST_IDLE) | hold_vld;

endmodule

// File: tb/tb_o_serdes_tx.sv
// ----------------------------------------------------------------------------
// tb_o_serdes_tx
//   Two gearbox instances with W=8:
//     u0: LSB_FIRST=1, OE_LEAD=0, OE_TRAIL=1
//     u1: LSB_FIRST=0, OE_LEAD=2, OE_TRAIL=3
//   A queue-of-output-symbols model predicts Q/OE/BUSY/DATA_READY each cycle;
//   literal sequences pin the model for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_o_serdes_tx;

    localparam int LSB_P   [2] = '{1, 0};
    localparam int LEAD_P  [2] = '{0, 2};
    localparam int TRAIL_P [2] = '{1, 3};

    localparam int K_LEAD  = 1;
    localparam int K_BEAT  = 2;
    localparam int K_TRAIL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [2];
    logic       en    [2];
    logic       vld   [2];
    logic [7:0] din   [2];
    logic [1:0] dq    [2];
    logic       doe   [2];
    logic       dbusy [2];
    logic       drdy  [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [2:0] hist [2][0:511];

    // model state
    logic       mh_v [2];
    logic [7:0] mh_d [2];
    logic [1:0] mq   [2];
    logic       moe  [2];
    int         rb   [2][16];
    int         rh   [2];
    int         rc   [2];

    for (genvar g = 0; g < 2; g++) begin : g_u
        o_serdes_tx_if #(.DATA_WIDTH(8)) bus ();
        assign bus.DATA_IN    = din[g];
        assign bus.DATA_VALID = vld[g];
        assign drdy[g]        = bus.DATA_READY;

        o_serdes_tx #(
            .DATA_WIDTH (8),
            .LSB_FIRST  (LSB_P[g] != 0),
            .OE_LEAD    (LEAD_P[g]),
            .OE_TRAIL   (TRAIL_P[g]),
            .IDLE_PAT   (2'b00)
        ) dut (
            .C    (clk),
            .R    (rst_n[g]),
            .EN   (en[g]),
            .s_if (bus.slave),
            .Q    (dq[g]),
            .OE   (doe[g]),
            .BUSY (dbusy[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] beat_of(input logic [7:0] w, input int i, input int lsb);
        if (lsb != 0) return {w[2*i+1], w[2*i]};
        else          return {w[6-2*i], w[7-2*i]};
    endfunction

    task automatic m_reset(input int d);
        mh_v[d] = 1'b0; mh_d[d] = 8'h00; mq[d] = 2'b00; moe[d] = 1'b0;
        rh[d] = 0; rc[d] = 0;
    endtask

    task automatic m_push(input int d, input int e);
        rb[d][(rh[d] + rc[d]) % 16] = e;
        rc[d]++;
    endtask

    // One clock edge of the model: the output queue holds one symbol per
    // future cycle. A held word is scheduled once nothing but trail symbols
    // is pending; from an idle line it is preceded by the lead symbols.
    task automatic m_step(input int d);
        bit take;
        bit pending;
        int e;
        if (!rst_n[d]) begin
            m_reset(d);
            return;
        end
        if (!en[d]) return;
        take    = vld[d] && !mh_v[d];
        pending = 1'b0;
        for (int i = 0; i < rc[d]; i++)
            if (rb[d][(rh[d] + i) % 16] / 4 != K_TRAIL) pending = 1'b1;
        if (mh_v[d] && !pending) begin
            if (!moe[d] && LEAD_P[d] > 0) begin
                for (int i = 0; i < LEAD_P[d]; i++) m_push(d, K_LEAD * 4);
            end else begin
                rc[d] = 0;
                for (int i = 0; i < 4; i++)
                    m_push(d, K_BEAT * 4 + int'(beat_of(mh_d[d], i, LSB_P[d])));
                for (int i = 0; i < TRAIL_P[d]; i++) m_push(d, K_TRAIL * 4);
                mh_v[d] = 1'b0;
            end
        end
        if (rc[d] > 0) begin
            e     = rb[d][rh[d]];
            rh[d] = (rh[d] + 1) % 16;
            rc[d]--;
            moe[d] = 1'b1;
            mq[d]  = (e / 4 == K_BEAT) ? 2'(e % 4) : 2'b00;
        end else begin
            moe[d] = 1'b0;
            mq[d]  = 2'b00;
        end
        if (take) begin
            mh_v[d] = 1'b1;
            mh_d[d] = din[d];
        end
    endtask

    // Advance one cycle and compare both instances against the model.
    task automatic tick();
        @(posedge clk);
        m_step(0);
        m_step(1);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (cyc < 512) hist[d][cyc] = {doe[d], dq[d]};
            chk($sformatf("u%0d_q_c%0d", d, cyc),     int'(dq[d]),    int'(mq[d]));
            chk($sformatf("u%0d_oe_c%0d", d, cyc),    int'(doe[d]),   int'(moe[d]));
            chk($sformatf("u%0d_busy_c%0d", d, cyc),  int'(dbusy[d]), int'(mh_v[d] | moe[d]));
            chk($sformatf("u%0d_ready_c%0d", d, cyc), int'(drdy[d]),  int'(en[d] & ~mh_v[d]));
        end
    endtask

    task automatic send(input int d, input logic [7:0] w, output int k);
        bit ok;
        ok     = 1'b0;
        k      = -1;
        din[d] = w;
        vld[d] = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            ok = drdy[d] && en[d];
            tick();
            if (ok) k = cyc;
        end
        if (!ok) chk($sformatf("u%0d_send_timeout", d), 0, 1);
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 100 && cyc < target; n++) tick();
    endtask

    task automatic chk_hist(input string name, input int d, input int idx, input int exp);
        if (idx >= 0 && idx < 512) chk(name, int'(hist[d][idx]), exp);
        else chk({name, "_range"}, idx, 0);
    endtask

    initial begin
        // {OE,Q} expected literals
        int t2 [7]  = '{0, 4, 5, 7, 6, 4, 0};
        int t3 [10] = '{5, 5, 6, 6, 4, 7, 7, 4, 4, 0};
        int t4 [10] = '{4, 4, 5, 7, 6, 4, 4, 4, 4, 0};
        int t5 [9]  = '{4, 5, 5, 5, 5, 7, 6, 4, 0};
        int t6 [17] = '{4, 4, 6, 6, 5, 5, 4, 4, 4, 7, 4, 4, 7, 4, 4, 4, 0};
        int k;
        int k2;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; en[d] = 1'b1; vld[d] = 1'b1; din[d] = 8'hAA;
            m_reset(d);
        end

        // 1. reset with VALID high, then release with VALID low
        tick();
        tick();
        chk("t1_rst_q",    int'(dq[0]),    0);
        chk("t1_rst_oe",   int'(doe[0]),   0);
        chk("t1_rst_busy", int'(dbusy[0]), 0);
        vld[0] = 1'b0; vld[1] = 1'b0;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        k = cyc;
        run_to(k + 3);
        chk("t1_ready", int'(drdy[0]), 1);
        for (int i = 1; i <= 3; i++) chk_hist($sformatf("t1_idle_%0d", i), 0, k + i, 0);

        // 2. single word, LSB first, no lead, one trail cycle
        send(0, 8'hB4, k);
        vld[0] = 1'b0;
        run_to(k + 6);
        for (int i = 0; i < 7; i++) chk_hist($sformatf("t2_k%0d", i), 0, k + i, t2[i]);

        // 3. back-to-back words with VALID held high
        send(0, 8'hA5, k);
        send(0, 8'h3C, k2);
        vld[0] = 1'b0;
        run_to(k + 10);
        for (int i = 0; i < 10; i++) chk_hist($sformatf("t3_k%0d", i + 1), 0, k + i + 1, t3[i]);

        // 4. MSB first with two lead cycles
        send(1, 8'hB4, k);
        vld[1] = 1'b0;
        run_to(k + 10);
        for (int i = 0; i < 10; i++) chk_hist($sformatf("t4_k%0d", i + 1), 1, k + i + 1, t4[i]);

        // 5. EN low for three cycles after beat 1
        send(0, 8'hB4, k);
        vld[0] = 1'b0;
        run_to(k + 2);
        en[0] = 1'b0;
        tick();
        chk("t5_ready_frozen", int'(drdy[0]), 0);
        tick();
        tick();
        en[0] = 1'b1;
        run_to(k + 9);
        for (int i = 0; i < 9; i++) chk_hist($sformatf("t5_k%0d", i + 1), 0, k + i + 1, t5[i]);

        // 6. second word arrives during trail cycle 2: no lead, OE stays high
        send(1, 8'h5A, k);
        vld[1] = 1'b0;
        run_to(k + 8);
        send(1, 8'hC3, k2);
        vld[1] = 1'b0;
        chk("t6_accept_edge", k2 - k, 9);
        run_to(k + 17);
        for (int i = 0; i < 17; i++) chk_hist($sformatf("t6_k%0d", i + 1), 1, k + i + 1, t6[i]);

        // reset in the middle of a word
        send(0, 8'hFF, k);
        vld[0] = 1'b0;
        run_to(k + 2);
        chk_hist("t7_midword", 0, k + 2, 7);
        rst_n[0] = 1'b0;
        #1;
        chk("t7_rst_q",    int'(dq[0]),    0);
        chk("t7_rst_oe",   int'(doe[0]),   0);
        chk("t7_rst_busy", int'(dbusy[0]), 0);
        m_reset(0);
        tick();
        rst_n[0] = 1'b1;
        run_to(k + 9);
        for (int i = 3; i <= 9; i++) chk_hist($sformatf("t7_after_%0d", i), 0, k + i, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
